counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl_pkg.sv | 21 ++
 rtl/counter_ctrl_wdog.sv | 39 +++
 rtl/counter_ctrl.sv | 163 ++++++++++++++++
 tb/tb_counter_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter controller: command ops, FSM states and
// the default WAIT-state timeout used when COUNTER_CTRL_TIMEOUT_EN is defined.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_START  = 2'd1,
        OP_STOP   = 2'd2,
        OP_RUN_TO = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RUN   = 2'd3
    } ctrl_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/counter_ctrl_wdog.sv
// WAIT-state watchdog: counts consecutive enabled cycles and flags the
// TIMEOUT-th one. Only instantiated when COUNTER_CTRL_TIMEOUT_EN is defined.
module counter_ctrl_wdog
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count 0 is the first enabled cycle, so the flag rises in cycle TIMEOUT.
    assign expired_o = en_i && (count_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (!en_i) begin
            count_d = '0;
        end else if (!expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Command front-end for a counter core: accepts LOAD/START/STOP/RUN_TO,
// strobes the core and reports completion. Macro: COUNTER_CTRL_TIMEOUT_EN.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        start,
    output logic        stop,
    output logic        load_en,
    output logic [31:0] load_val,
    input  logic        active,
    input  logic [31:0] counter,
    output logic        done,
    output logic        err
);

    ctrl_state_e state_q, state_d;
    cmd_op_e     op_q, op_d;
    logic [31:0] data_q, data_d;
    logic        skip_q, skip_d;
    logic        start_q, start_d;
    logic        stop_q, stop_d;
    logic        load_en_q, load_en_d;
    logic        wait_exit;
    logic        run_stop;
    logic        done_c;
    cmd_op_e     new_op;

    assign new_op    = cmd_op_e'(cmd_op);
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign start     = start_q;
    assign load_en   = load_en_q;
    assign stop      = stop_q | run_stop;
    assign load_val  = data_q;
    assign done      = done_c;

`ifdef COUNTER_CTRL_TIMEOUT_EN
    logic wdog_expired;
    logic err_c;

    counter_ctrl_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == ST_WAIT),
        .expired_o (wdog_expired)
    );

    assign err = err_c;
`else
    // No watchdog to size here; still reject a meaningless setting.
    if (TIMEOUT == 0) begin : g_timeout_check
        $error("counter_ctrl: TIMEOUT must be non-zero");
    end

    assign err = 1'b0;
`endif

    always_comb begin
        wait_exit = 1'b0;
        unique case (op_q)
            OP_LOAD:             wait_exit = (counter == data_q);
            OP_START, OP_RUN_TO: wait_exit = active;
            OP_STOP:             wait_exit = !active;
            default:             wait_exit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        skip_d    = skip_q;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        load_en_d = 1'b0;
        run_stop  = 1'b0;
        done_c    = 1'b0;
`ifdef COUNTER_CTRL_TIMEOUT_EN
        err_c     = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = ST_ISSUE;
                    op_d    = new_op;
                    data_d  = cmd_data;
                    // A RUN_TO already sitting on its target completes with no strobe.
                    skip_d  = (new_op == OP_RUN_TO) && (cmd_data == counter);
                    unique case (new_op)
                        OP_LOAD:   load_en_d = 1'b1;
                        OP_START:  start_d   = 1'b1;
                        OP_STOP:   stop_d    = 1'b1;
                        OP_RUN_TO: start_d   = (cmd_data != counter);
                        default:   start_d   = 1'b0;
                    endcase
                end
            end
            ST_ISSUE: begin
                if (skip_q) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_exit) begin
                    if (op_q == OP_RUN_TO) begin
                        state_d = ST_RUN;
                    end else begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
`ifdef COUNTER_CTRL_TIMEOUT_EN
                else if (wdog_expired) begin
                    err_c   = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_RUN: begin
                // Stop is combinational so the core halts holding the target value.
                if ((counter == data_q) || !active) begin
                    run_stop = 1'b1;
                    op_d     = OP_STOP;
                    state_d  = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LOAD;
            data_q    <= 32'd0;
            skip_q    <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            load_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            skip_q    <= skip_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            load_en_q <= load_en_d;
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl with a behavioural counter core; expectations come
// from per-command latency/strobe rules computed with plain arithmetic.
module tb_counter_ctrl;

    localparam logic [1:0] OP_LOAD   = 2'd0;
    localparam logic [1:0] OP_START  = 2'd1;
    localparam logic [1:0] OP_STOP   = 2'd2;
    localparam logic [1:0] OP_RUN_TO = 2'd3;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        start;
    logic        stop;
    logic        load_en;
    logic [31:0] load_val;
    logic        core_act;
    logic [31:0] core_cnt;
    logic        done;
    logic        err;
    logic        stub_mode;
    logic        ext_drop;

    int total;
    int bad;
    int done_cyc, err_cyc, stop_cyc;
    int n_start, n_stop, n_load, n_done, n_err, multi, busy_ready;
    logic [31:0] lv, stop_val, done_counter;

    counter_ctrl #(
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .start     (start),
        .stop      (stop),
        .load_en   (load_en),
        .load_val  (load_val),
        .active    (core_act),
        .counter   (core_cnt),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counter core: load wins over counting, stop/drop halt before the increment.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_cnt <= 32'd0;
            core_act <= 1'b0;
        end else begin
            if (load_en) core_cnt <= load_val;
            else if (core_act && !stop && !ext_drop) core_cnt <= core_cnt + 32'd1;
            if (stop || ext_drop) core_act <= 1'b0;
            else if (start && !stub_mode) core_act <= 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents the command and returns just after the accepting edge.
    task automatic accept(input logic [1:0] op, input logic [31:0] data, input bit hold,
                          input logic [1:0] nop, input logic [31:0] ndata);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        chk("ready_at_offer", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        if (hold) begin
            cmd_op   = nop;
            cmd_data = ndata;
        end else begin
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom);
            cmd_data  = $urandom;
        end
    endtask

    task automatic watch(input int budget, input int drop_at);
        done_cyc = 0; err_cyc = 0; stop_cyc = 0;
        n_start = 0; n_stop = 0; n_load = 0; n_done = 0; n_err = 0;
        multi = 0; busy_ready = 0;
        lv = 32'd0; stop_val = 32'd0; done_counter = 32'd0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            ext_drop = (cyc == drop_at);
            n_start += int'(start);
            n_stop  += int'(stop);
            n_load  += int'(load_en);
            if (int'(start) + int'(stop) + int'(load_en) > 1) multi++;
            if (cmd_ready) busy_ready++;
            if (load_en) lv = load_val;
            if (stop) begin
                stop_val = core_cnt;
                stop_cyc = cyc;
            end
            if (err) begin
                n_err++;
                if (err_cyc == 0) err_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc     = cyc;
                done_counter = core_cnt;
            end
            if (done || err) break;
        end
        ext_drop = 1'b0;
    endtask

    task automatic finish_cmd();
        @(negedge clk);
        chk("done_after", 32'(done), 32'd0);
        chk("err_after", 32'(err), 32'd0);
        chk("ready_after", 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [31:0] data, input bit hold,
                           input logic [1:0] nop, input logic [31:0] ndata);
        logic [31:0] d;
        int e_lat, e_start, e_stop, e_load;
        d = data - core_cnt;
        e_lat = 2; e_start = 0; e_stop = 0; e_load = 0;
        case (op)
            OP_LOAD:  e_load  = 1;
            OP_START: e_start = 1;
            OP_STOP:  e_stop  = 1;
            default: begin
                if (d == 32'd0) begin
                    e_lat = 1;
                end else begin
                    e_lat   = 3 + int'(d);
                    e_start = 1;
                    e_stop  = 1;
                end
            end
        endcase
        accept(op, data, hold, nop, ndata);
        watch(e_lat + 8, 0);
        chk("latency", done_cyc, e_lat);
        chk("n_done", n_done, 1);
        chk("n_start", n_start, e_start);
        chk("n_stop", n_stop, e_stop);
        chk("n_load", n_load, e_load);
        chk("one_hot", multi, 0);
        chk("busy_ready", busy_ready, 0);
        chk("n_err", n_err, 0);
        if (op == OP_LOAD) begin
            chk("load_val", lv, data);
            chk("load_counter", done_counter, data);
        end
        if (op == OP_RUN_TO && e_stop == 1) begin
            chk("stop_at_target", stop_val, data);
            chk("done_counter", done_counter, data);
        end
        finish_cmd();
        if (op == OP_RUN_TO) chk("run_hold", core_cnt, data);
        if (op == OP_RUN_TO || op == OP_STOP) chk("core_idle", 32'(core_act), 32'd0);
        if (op == OP_START) chk("core_running", 32'(core_act), 32'd1);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_stop", 32'(stop), 32'd0);
        chk("rst_load_en", 32'(load_en), 32'd0);
        chk("rst_load_val", load_val, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_done_hold", 32'(done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_post_rst", 32'(cmd_ready), 32'd1);
        chk("done_post_rst", 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] tgt;
        logic [1:0]  rop;
        logic [31:0] rdata;
        total = 0; bad = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 32'd0;
        stub_mode = 1'b0; ext_drop = 1'b0;

        // Power-on reset values, then ready in the first cycle after release.
        #3;
        reset_pulse();

        run_cmd(OP_LOAD, 32'h0000_1234, 1'b0, 2'd0, 32'd0);
        run_cmd(OP_LOAD, 32'd0, 1'b0, 2'd0, 32'd0);
        // RUN_TO 10 with the next command held on cmd_valid the whole time.
        run_cmd(OP_RUN_TO, 32'd10, 1'b1, OP_LOAD, 32'hFFFF_FFFE);
        run_cmd(OP_LOAD, 32'hFFFF_FFFE, 1'b0, 2'd0, 32'd0);
        run_cmd(OP_RUN_TO, 32'd2, 1'b0, 2'd0, 32'd0);
        run_cmd(OP_RUN_TO, 32'd2, 1'b0, 2'd0, 32'd0);
        run_cmd(OP_START, $urandom, 1'b0, 2'd0, 32'd0);
        run_cmd(OP_STOP, $urandom, 1'b0, 2'd0, 32'd0);
        run_cmd(OP_STOP, $urandom, 1'b0, 2'd0, 32'd0);

        // Core drops active on its own while in RUN.
        tgt = core_cnt + 32'd30;
        accept(OP_RUN_TO, tgt, 1'b0, 2'd0, 32'd0);
        watch(20, 5);
        chk("drop_stop_cyc", stop_cyc, 6);
        chk("drop_done_cyc", done_cyc, 7);
        chk("drop_n_start", n_start, 1);
        chk("drop_n_stop", n_stop, 1);
        chk("drop_one_hot", multi, 0);
        finish_cmd();
        chk("drop_core_idle", 32'(core_act), 32'd0);

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom_range(0, 3));
            if (rop == OP_RUN_TO && core_act) rop = OP_STOP;
            case (rop)
                OP_LOAD:   rdata = ($urandom_range(0, 1) == 1) ? $urandom
                                   : 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                OP_RUN_TO: rdata = core_cnt + 32'($urandom_range(0, 12));
                default:   rdata = $urandom;
            endcase
            run_cmd(rop, rdata, 1'b0, 2'd0, 32'd0);
        end

        // Reset landing in the middle of a RUN.
        run_cmd(OP_STOP, 32'd0, 1'b0, 2'd0, 32'd0);
        tgt = core_cnt + 32'd40;
        accept(OP_RUN_TO, tgt, 1'b0, 2'd0, 32'd0);
        repeat (5) @(negedge clk);
        reset_pulse();

        // Core that never raises active.
        stub_mode = 1'b1;
        accept(OP_START, 32'd0, 1'b0, 2'd0, 32'd0);
        watch(40, 0);
`ifdef COUNTER_CTRL_TIMEOUT_EN
        chk("to_err_cyc", err_cyc, 17);
        chk("to_n_err", n_err, 1);
        chk("to_n_done", n_done, 0);
        chk("to_n_start", n_start, 1);
        finish_cmd();
`else
        chk("wait_n_done", n_done, 0);
        chk("wait_n_err", n_err, 0);
        chk("wait_busy_ready", busy_ready, 0);
        reset_pulse();
`endif
        stub_mode = 1'b0;
        run_cmd(OP_LOAD, 32'h0000_00AA, 1'b0, 2'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
